image_rd_if: RTL
================

Name: image_rd_if

Overview:
- Read-path counterpart to the sensor write path: fetches one stored frame from DDR through the memory arbiter's read port and pushes 128-bit words into the host-side output FIFO.
- Accepts a start address and word count from the image buffer coordinator.
- Issues single-UI-word read requests, throttled by a credit check on output FIFO space and by an outstanding-read limit.
- Runs entirely in the memory clock domain.

Parameters:
- ADDRESS_INCREMENT, 8, UI word-address step per request (BL8 burst, 1 UI word).
- FIFO_DEPTH, 512, output FIFO depth in 128-bit words.
- MAX_OUTSTANDING, 16, maximum acknowledged reads awaiting data.
- CNT_W, 10, width of fifo_wr_data_count.

Ports:
- mem_clk  in  1  memory/UI clock; sole clock.
- mem_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse requesting a frame read.
- start_addr  in  30  frame start address; bits [28:0] used.
- frame_words  in  20  frame length in 128-bit words.
- abort  in  1  one-cycle pulse that cancels the current frame.
- ready  out  1  high in idle; start is accepted only while high.
- frame_read  out  1  one-cycle pulse when all words of a frame are delivered.
- aborted  out  1  one-cycle pulse when an abort completes.
- mem_rd_req  out  1  read request to arbiter; held until ack.
- mem_rd_addr  out  29  UI read address.
- mem_rd_ack  in  1  arbiter accepts the request.
- mem_rd_data_valid  in  1  read data return strobe.
- mem_rd_data  in  128  read data.
- fifo_wr_en  out  1  output FIFO write enable.
- fifo_wr_data  out  128  output FIFO write data.
- fifo_wr_data_count  in  CNT_W  output FIFO occupancy.
- fifo_full  in  1  output FIFO full.
- err_count  out  8  saturating count of unexpected data and overflow events.

Behaviour:
- Reset (async assert, sync release): state=s_idle, all outputs 0, remaining=0, outstanding=0. ready rises 1 cycle after release.
- States are s_idle, s_issue, s_wait_ack, s_drain.
- s_idle:
  - ready=1.
  - start with frame_words!=0 → latch mem_rd_addr=start_addr[28:0] and remaining=frame_words, ready=0, go to s_issue.
  - start with frame_words==0 → frame_read pulses the next cycle, stay in s_idle.
  - abort in s_idle is ignored.
- s_issue:
  - Issue when remaining>0, outstanding<MAX_OUTSTANDING, and fifo_wr_data_count+outstanding+1 <= FIFO_DEPTH. Issuing asserts mem_rd_req (registered) and moves to s_wait_ack.
  - remaining==0 → go to s_drain.
- s_wait_ack:
  - mem_rd_req stays high until the cycle mem_rd_ack is sampled.
  - On ack: mem_rd_req=0 next cycle, mem_rd_addr+=ADDRESS_INCREMENT (wraps modulo 2^29), remaining−1, outstanding+1, return to s_issue.
  - Minimum spacing is 2 cycles between requests.
- Data path:
  - fifo_wr_en/fifo_wr_data are mem_rd_data_valid/mem_rd_data registered: exactly 1-cycle latency, no reordering. The data path is active in every state.
  - Each valid decrements outstanding.
  - Ack and valid in the same cycle → outstanding unchanged.
  - Valid with outstanding==0 → data still forwarded, err_count+1.
  - fifo_wr_en while fifo_full → err_count+1.
  - err_count saturates at 255.
- s_drain: when outstanding==0 and the final fifo_wr_en has been issued → frame_read pulse, go to s_idle.
- abort in s_issue, s_wait_ack or s_drain:
  - Stop issuing immediately. A request already raised in s_wait_ack is held until ack, then counted.
  - Move to s_drain with an abort flag set; outstanding data is still forwarded.
  - On drain completion: aborted pulses instead of frame_read.
- start outside s_idle is ignored.
- frame_read and aborted never pulse together.

Test Plan:
- Normal frame: start_addr=0x100, frame_words=4, ack 1 cycle after each req, data 5 cycles after ack → addrs 0x100/0x108/0x110/0x118, 4 fifo_wr_en in order, frame_read 1 pulse, err_count=0.
- Credit throttle: fifo_wr_data_count=510, frame_words=8, arbiter never returns data → exactly 2 acks then mem_rd_req stays low; lowering count to 0 resumes issuing.
- Outstanding limit: frame_words=32, data withheld → exactly 16 acks; first valid allows the 17th request.
- Address wrap plus simultaneous ack/valid: start_addr[28:0]=0x1FFFFFF8, frame_words=2 → addrs 0x1FFFFFF8 then 0x00000000; ack and valid coincident keeps outstanding correct; frame_read pulses.
- Abort mid-frame: frame_words=100, abort after 10 acks with 3 pending → no further req, 3 more fifo_wr_en, aborted pulse, frame_read never pulses, ready=1.
- Errors and reset: valid in idle → err_count=1. mem_reset_n low mid-frame → all outputs 0 asynchronously. After release, a frame_words=0 start → frame_read next cycle, no req.

Source files
------------

// File: rtl/image_rd_if.sv
// image_rd_if
// Read path from DDR to the host-side output FIFO. A frame (start address
// and word count from the image buffer coordinator) is fetched as one UI-word
// read request at a time. Issuing is gated by free space in the output FIFO
// and by a cap on reads that have been acknowledged but have not yet returned
// data. Returned data is forwarded to the FIFO with a fixed 1-cycle latency.
// Everything runs in the memory clock domain.
//
// Ports
//   mem_clk, mem_reset_n          clock, async active-low reset
//   start/start_addr/frame_words  frame request (accepted only while ready)
//   abort                         cancel current frame
//   ready/frame_read/aborted      status and completion pulses
//   mem_rd_req/addr/ack           arbiter read request handshake
//   mem_rd_data_valid/data        arbiter read data return
//   fifo_wr_en/data               output FIFO write
//   fifo_wr_data_count/full       output FIFO status
//   err_count                     saturating error event counter
//
// state      | meaning
// s_idle     | waiting for start, ready high
// s_issue    | decide whether the next read may be requested
// s_wait_ack | request raised, held until the arbiter acks it
// s_drain    | no more requests; wait for outstanding data, then pulse

module image_rd_if #(
    parameter int ADDRESS_INCREMENT = 8,
    parameter int FIFO_DEPTH        = 512,
    parameter int MAX_OUTSTANDING   = 16,
    parameter int CNT_W             = 10
) (
    input  logic               mem_clk,
    input  logic               mem_reset_n,
    input  logic               start,
    input  logic [29:0]        start_addr,
    input  logic [19:0]        frame_words,
    input  logic               abort,
    output logic               ready,
    output logic               frame_read,
    output logic               aborted,
    output logic               mem_rd_req,
    output logic [28:0]        mem_rd_addr,
    input  logic               mem_rd_ack,
    input  logic               mem_rd_data_valid,
    input  logic [127:0]       mem_rd_data,
    output logic               fifo_wr_en,
    output logic [127:0]       fifo_wr_data,
    input  logic [CNT_W-1:0]   fifo_wr_data_count,
    input  logic               fifo_full,
    output logic [7:0]         err_count
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {s_idle, s_issue, s_wait_ack, s_drain} state_t;

    state_t       state_q, state_d;
    logic [28:0]  addr_q, addr_d;
    logic [19:0]  remaining_q, remaining_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic         req_q, req_d;
    logic         ready_q, ready_d;
    logic         frame_read_q, frame_read_d;
    logic         aborted_q, aborted_d;
    logic         abort_flag_q, abort_flag_d;
    logic         fifo_wr_en_q, fifo_wr_en_d;
    logic [127:0] fifo_wr_data_q, fifo_wr_data_d;
    logic [7:0]   err_count_q, err_count_d;

    logic         ack_take;
    logic         can_issue;
    logic [31:0]  credit_need;
    logic         unexpected;
    logic         overflow;
    logic [8:0]   err_sum;
    logic         unused_addr_msb;

    // Only a 29-bit UI address space exists; the top address bit is ignored.
    assign unused_addr_msb = start_addr[29];

    // Reads in flight plus the one about to be issued must fit in the FIFO.
    assign credit_need = 32'(fifo_wr_data_count) + 32'(outstanding_q) + 32'd1;
    assign can_issue   = (remaining_q != 20'd0)
                      && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                      && (credit_need <= 32'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        req_d        = req_q;
        abort_flag_d = abort_flag_q;
        frame_read_d = 1'b0;
        aborted_d    = 1'b0;
        ack_take     = 1'b0;

        case (state_q)
            s_idle: begin
                abort_flag_d = 1'b0;
                if (start && ready_q) begin
                    if (frame_words != 20'd0) begin
                        addr_d      = start_addr[28:0];
                        remaining_d = frame_words;
                        state_d     = s_issue;
                    end else begin
                        frame_read_d = 1'b1;
                    end
                end
            end
            s_issue: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                    state_d      = s_drain;
                end else if (remaining_q == 20'd0) begin
                    state_d = s_drain;
                end else if (can_issue) begin
                    req_d   = 1'b1;
                    state_d = s_wait_ack;
                end
            end
            s_wait_ack: begin
                // A raised request cannot be withdrawn; an abort is remembered
                // and takes effect once the arbiter has accepted it.
                if (abort) begin
                    abort_flag_d = 1'b1;
                end
                if (mem_rd_ack) begin
                    ack_take    = 1'b1;
                    req_d       = 1'b0;
                    addr_d      = addr_q + 29'(ADDRESS_INCREMENT);
                    remaining_d = remaining_q - 20'd1;
                    state_d     = (abort || abort_flag_q) ? s_drain : s_issue;
                end
            end
            s_drain: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                end
                // The last data word was written to the FIFO this cycle at the
                // latest, so the completion pulse follows it.
                if (outstanding_q == '0) begin
                    if (abort || abort_flag_q) begin
                        aborted_d = 1'b1;
                    end else begin
                        frame_read_d = 1'b1;
                    end
                    state_d = s_idle;
                end
            end
            default: state_d = s_idle;
        endcase

        ready_d = (state_d == s_idle);
    end

    always_comb begin
        fifo_wr_en_d   = mem_rd_data_valid;
        fifo_wr_data_d = mem_rd_data;

        unexpected = mem_rd_data_valid && (outstanding_q == '0);
        overflow   = fifo_wr_en_q && fifo_full;

        outstanding_d = outstanding_q;
        if (ack_take && !(mem_rd_data_valid && !unexpected)) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!ack_take && mem_rd_data_valid && !unexpected) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end

        err_sum     = {1'b0, err_count_q} + 9'(unexpected) + 9'(overflow);
        err_count_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state_q        <= s_idle;
            addr_q         <= '0;
            remaining_q    <= '0;
            outstanding_q  <= '0;
            req_q          <= 1'b0;
            ready_q        <= 1'b0;
            frame_read_q   <= 1'b0;
            aborted_q      <= 1'b0;
            abort_flag_q   <= 1'b0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            outstanding_q  <= outstanding_d;
            req_q          <= req_d;
            ready_q        <= ready_d;
            frame_read_q   <= frame_read_d;
            aborted_q      <= aborted_d;
            abort_flag_q   <= abort_flag_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            err_count_q    <= err_count_d;
        end
    end

    assign ready        = ready_q;
    assign frame_read   = frame_read_q;
    assign aborted      = aborted_q;
    assign mem_rd_req   = req_q;
    assign mem_rd_addr  = addr_q;
    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_wr_data = fifo_wr_data_q;
    assign err_count    = err_count_q;

endmodule
